// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame states, key event payload, scan-code set 2 prefixes and ignored codes.
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_key_event_t;

    typedef struct packed {
        logic       extended;
        logic [7:0] code;
        logic       valid;
    } ps2_last_make_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Keyboard status/ack codes that never represent a key
    localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
    localparam logic [7:0] PS2_IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
    localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
    localparam logic [7:0] PS2_IGN_ERR1   = 8'hFF;

    localparam int unsigned PS2_FRAME_DATA_BITS = 8;

    function automatic logic ps2_is_ignored(input logic [7:0] b);
        return (b == PS2_IGN_ERR0)   || (b == PS2_IGN_BAT_OK) ||
               (b == PS2_IGN_ECHO)   || (b == PS2_IGN_ACK)    ||
               (b == PS2_IGN_RESEND) || (b == PS2_IGN_ERR1);
    endfunction

    function automatic int unsigned ps2_timeout_cycles(input int unsigned clk_hz,
                                                       input int unsigned timeout_us);
        return (clk_hz / 32'd1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// 11-bit frame FSM with odd-parity/stop checking and an inter-edge watchdog.
module ps2_frame_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_strobe_o,
    output logic       frame_error_o,
    output logic       abort_o
);

    localparam int unsigned LIMIT  = ps2_timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int unsigned WDOG_W = $clog2(LIMIT + 1);
    localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned CNT_W  = $clog2(PS2_FRAME_DATA_BITS);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_s;
    logic       dat_s;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    logic              filt_q;
    logic              filt_d;
    logic [FILT_W-1:0] filt_cnt_q;
    logic [FILT_W-1:0] filt_cnt_d;
    logic              filt_accept_c;
    logic              fall_c;

    // A new clock level is accepted after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d        = filt_q;
        filt_cnt_d    = '0;
        filt_accept_c = 1'b0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_accept_c = 1'b1;
                filt_d        = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign fall_c = filt_accept_c & filt_q;

    ps2_rx_state_t    state_q;
    ps2_rx_state_t    state_d;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WDOG_W-1:0] wdog_q;
    logic             timeout_c;
    logic             strobe_c;
    logic             err_c;
    logic             abort_c;

    assign timeout_c = (state_q != IDLE) && !fall_c && (wdog_q == WDOG_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (fall_c) begin
            case (state_q)
                IDLE:    if (!dat_s) state_d = DATA;
                DATA:    if (bit_cnt_q == CNT_W'(PS2_FRAME_DATA_BITS - 1)) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stop bit must be high and data plus parity must carry an odd number of ones
    always_comb begin
        strobe_c = 1'b0;
        err_c    = 1'b0;
        abort_c  = 1'b0;
        if (timeout_c) begin
            err_c   = 1'b1;
            abort_c = 1'b1;
        end else if (fall_c) begin
            case (state_q)
                IDLE: begin
                    if (dat_s) err_c = 1'b1;
                end
                STOP: begin
                    if (dat_s && (^{shift_q, par_q})) begin
                        strobe_c = 1'b1;
                    end else begin
                        err_c   = 1'b1;
                        abort_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else if (fall_c) begin
            case (state_q)
                IDLE:   bit_cnt_q <= '0;
                DATA: begin
                    shift_q   <= {dat_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
                PARITY: par_q <= dat_s;
                default: ;
            endcase
        end
    end

    // Watchdog: restarts on every sampling edge, runs only mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if ((state_q == IDLE) || fall_c || timeout_c) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_o        <= '0;
            byte_strobe_o <= 1'b0;
            frame_error_o <= 1'b0;
            abort_o       <= 1'b0;
        end else begin
            byte_strobe_o <= strobe_c;
            frame_error_o <= err_c;
            abort_o       <= abort_c;
            if (strobe_c) byte_o <= shift_q;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames to scan-code set 2 make/break events on a
// valid/ready register. Optional auto-repeat suppression: PS2_TYPEMATIC_FILTER_EN.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       frame_error,
    output logic       overflow
);

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_error;
    logic       rx_abort;

    ps2_frame_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .FILTER_LEN  (FILTER_LEN)
    ) u_frame_rx (
        .clk           (CLOCK_50),
        .rst_n         (reset_n),
        .ps2_clk_i     (ps2_clk),
        .ps2_dat_i     (ps2_dat),
        .byte_o        (rx_byte),
        .byte_strobe_o (rx_strobe),
        .frame_error_o (rx_error),
        .abort_o       (rx_abort)
    );

    logic           ext_q;
    logic           ext_d;
    logic           brk_q;
    logic           brk_d;
    ps2_key_event_t dec_ev_c;
    logic           dec_valid_c;

    // Prefix decoder: prefixes arm flags, status codes vanish, anything else is a key
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        dec_valid_c = 1'b0;
        dec_ev_c    = '{extended: ext_q, released: brk_q, code: rx_byte};
        if (rx_abort) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_strobe) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else if (!ps2_is_ignored(rx_byte)) begin
                dec_valid_c = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    logic emit_c;

`ifdef PS2_TYPEMATIC_FILTER_EN
    ps2_last_make_t last_q;
    ps2_last_make_t last_d;
    logic           last_hit_c;

    // Repeated makes of the held key are swallowed; its break re-arms the filter
    always_comb begin
        emit_c     = dec_valid_c;
        last_d     = last_q;
        last_hit_c = last_q.valid && (last_q.extended == dec_ev_c.extended) &&
                     (last_q.code == dec_ev_c.code);
        if (dec_valid_c) begin
            if (!dec_ev_c.released) begin
                if (last_hit_c) begin
                    emit_c = 1'b0;
                end else begin
                    last_d = '{extended: dec_ev_c.extended, code: dec_ev_c.code, valid: 1'b1};
                end
            end else if (last_hit_c) begin
                last_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign emit_c = dec_valid_c;
`endif

    ps2_key_event_t ev_q;
    logic           valid_q;
    logic           ovf_q;
    logic           ferr_q;
    logic           load_c;

    // New events load only into an empty or draining register; otherwise they drop
    assign load_c = emit_c && (!valid_q || key_ready);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ev_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= rx_error;
            if (load_c) begin
                ev_q    <= dec_ev_c;
                valid_q <= 1'b1;
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
            if (emit_c && valid_q && !key_ready) ovf_q <= 1'b1;
        end
    end

    assign key_valid    = valid_q;
    assign key_code     = ev_q.code;
    assign key_extended = ev_q.extended;
    assign key_released = ev_q.released;
    assign frame_error  = ferr_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed table, corner sequences and
// random frames against a byte-level decoding model.
module tb_ps2_keyboard_rx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned TO_US  = 200;
    localparam int          TO_CYC = 200;
    localparam int          HP     = 12;
    localparam int          SETTLE = 24;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int          TM_EXP = 2;
`else
    localparam int          TM_EXP = 4;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       key_ready;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       frame_error;
    logic       overflow;

    ps2_keyboard_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TIMEOUT_US  (TO_US),
        .FILTER_LEN  (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .key_ready    (key_ready),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_released (key_released),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vec_cnt = 0;
    int miscmp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Delivered events {ext, rel, code}, frame_error pulse count and protocol violations
    logic [9:0] got[$];
    int         err_cnt    = 0;
    int         hold_viol  = 0;
    int         width_viol = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_err   = 1'b0;
    logic [9:0] prev_ev    = '0;

    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if (key_valid && key_ready) got.push_back({key_extended, key_released, key_code});
            if (frame_error) err_cnt++;
            if (frame_error && prev_err) width_viol++;
            if (prev_valid && !prev_ready &&
                (!key_valid || ({key_extended, key_released, key_code} != prev_ev)))
                hold_viol++;
            prev_valid = key_valid;
            prev_ready = key_ready;
            prev_err   = frame_error;
            prev_ev    = {key_extended, key_released, key_code};
        end else begin
            prev_valid = 1'b0;
            prev_err   = 1'b0;
        end
    end

    // Byte-level reference model of the prefix decoder
    bit         m_ext;
    bit         m_brk;
    logic [9:0] exp_q[$];
    int         exp_err;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] m_last;
    bit         m_last_v;
`endif

    function automatic bit is_ign(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        exp_err = 0;
        exp_q.delete();
`ifdef PS2_TYPEMATIC_FILTER_EN
        m_last   = '0;
        m_last_v = 1'b0;
`endif
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        logic [9:0] e;
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            exp_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!is_ign(b)) begin
            e     = {m_ext, m_brk, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!e[8]) begin
                if (!(m_last_v && (m_last == {e[9], b}))) begin
                    m_last   = {e[9], b};
                    m_last_v = 1'b1;
                    exp_q.push_back(e);
                end
            end else begin
                if (m_last_v && (m_last == {e[9], b})) m_last_v = 1'b0;
                exp_q.push_back(e);
            end
`else
            exp_q.push_back(e);
`endif
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            ps2_dat = bits[k];
            repeat (HP) @(posedge CLOCK_50);
            #1 ps2_clk = 1'b0;
            repeat (HP) @(posedge CLOCK_50);
            #1 ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        repeat (SETTLE) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        model_reset();
        got.delete();
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic check_queue(input string tag);
        int n;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) chk({tag, "_event"}, 32'(got[k]), 32'(exp_q[k]));
        got.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad;
        bit         has_ev;
        logic [9:0] ev;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int         base;
        int         wcyc;
        int         ebase;
        logic [7:0] b;
        int         r;
        bit         bp;
        bit         bs;

        reset_n   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        key_ready = 1'b1;

        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C};
        tbl[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000};
        tbl[2]  = '{8'hF0, 1'b0, 1'b0, 10'h000};
        tbl[3]  = '{8'h75, 1'b0, 1'b1, 10'h375};
        tbl[4]  = '{8'h1C, 1'b1, 1'b0, 10'h000};
        tbl[5]  = '{8'hF0, 1'b0, 1'b0, 10'h000};
        tbl[6]  = '{8'h1C, 1'b0, 1'b1, 10'h11C};
        tbl[7]  = '{8'hAA, 1'b0, 1'b0, 10'h000};
        tbl[8]  = '{8'hE0, 1'b0, 1'b0, 10'h000};
        tbl[9]  = '{8'hFF, 1'b0, 1'b0, 10'h000};
        tbl[10] = '{8'h12, 1'b0, 1'b1, 10'h212};
        tbl[11] = '{8'hFE, 1'b0, 1'b0, 10'h000};
        tbl[12] = '{8'h5A, 1'b0, 1'b1, 10'h05A};
        tbl[13] = '{8'hF0, 1'b0, 1'b0, 10'h000};
        tbl[14] = '{8'hEE, 1'b0, 1'b0, 10'h000};
        tbl[15] = '{8'h5A, 1'b0, 1'b1, 10'h15A};
        tbl[16] = '{8'h00, 1'b0, 1'b0, 10'h000};

        repeat (2) @(negedge CLOCK_50);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_key_extended", 32'(key_extended), 32'd0);
        chk("rst_key_released", 32'(key_released), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        model_reset();
        repeat (10) @(posedge CLOCK_50);

        // A 3-cycle low glitch on an idle clock line must not register as a start edge
        base = err_cnt;
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("glitch_err", 32'(err_cnt - base), 32'd0);
        chk("glitch_events", 32'(got.size()), 32'd0);

        for (int i = 0; i < 17; i++) begin
            base = err_cnt;
            send_frame(tbl[i].data, tbl[i].bad, 1'b0);
            chk($sformatf("tbl%0d_err", i), 32'(err_cnt - base), 32'(tbl[i].bad));
            chk($sformatf("tbl%0d_count", i), 32'(got.size()), 32'(tbl[i].has_ev));
            if (tbl[i].has_ev && (got.size() > 0))
                chk($sformatf("tbl%0d_event", i), 32'(got[0]), 32'(tbl[i].ev));
            got.delete();
        end

        // Consumer stalls: first event held, second dropped with overflow
        chk("ovf_before", 32'(overflow), 32'd0);
        @(posedge CLOCK_50);
        #1 key_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        chk("stall_valid", 32'(key_valid), 32'd1);
        chk("stall_code", 32'(key_code), 32'h1C);
        chk("stall_ext_rel", 32'({key_extended, key_released}), 32'd0);
        chk("stall_overflow", 32'(overflow), 32'd1);
        @(posedge CLOCK_50);
        #1 key_ready = 1'b1;
        repeat (SETTLE) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("drain_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("drain_event", 32'(got[0]), 32'h01C);
        chk("drain_valid", 32'(key_valid), 32'd0);
        chk("drain_overflow_sticky", 32'(overflow), 32'd1);
        got.delete();

        // Clock stops after four data bits: watchdog aborts, next frame decodes
        base = err_cnt;
        send_bits(11'b000_0000_1010, 5);
        wcyc = 0;
        while ((err_cnt == base) && (wcyc < 3 * TO_CYC)) begin
            @(negedge CLOCK_50);
            wcyc++;
        end
        chk("timeout_err", 32'(err_cnt - base), 32'd1);
        chk("timeout_not_early", 32'(wcyc >= TO_CYC - 2 * HP), 32'd1);
        chk("timeout_events", 32'(got.size()), 32'd0);
        repeat (10) @(posedge CLOCK_50);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("after_to_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("after_to_event", 32'(got[0]), 32'h029);
        got.delete();

        // Auto-repeat sequence
        do_reset();
        chk("reset_clears_overflow", 32'(overflow), 32'd0);
        base = err_cnt;
        model_frame(8'h1C, 1'b1); send_frame(8'h1C, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b1); send_frame(8'h1C, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b1); send_frame(8'h1C, 1'b0, 1'b0);
        model_frame(8'hF0, 1'b1); send_frame(8'hF0, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b1); send_frame(8'h1C, 1'b0, 1'b0);
        chk("typematic_count_const", 32'(got.size()), 32'(TM_EXP));
        chk("typematic_err", 32'(err_cnt - base), 32'd0);
        check_queue("typematic");

        // Random frames against the model, with short consumer stalls
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: begin
                    case ($urandom_range(0, 5))
                        0: b = 8'h00;
                        1: b = 8'hAA;
                        2: b = 8'hEE;
                        3: b = 8'hFA;
                        4: b = 8'hFE;
                        default: b = 8'hFF;
                    endcase
                end
                3: b = 8'h1C;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 11) == 0);
            bs = !bp && ($urandom_range(0, 15) == 0);
            base  = err_cnt;
            ebase = exp_err;
            model_frame(b, !(bp || bs));
            send_bits(mk_frame(b, bp, bs), 11);
            @(posedge CLOCK_50);
            #1 key_ready = 1'b0;
            repeat ($urandom_range(0, 15)) @(posedge CLOCK_50);
            #1 key_ready = 1'b1;
            repeat (SETTLE) @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            chk($sformatf("rnd%0d_err", i), 32'(err_cnt - base), 32'(exp_err - ebase));
            check_queue($sformatf("rnd%0d", i));
        end
        chk("rnd_overflow", 32'(overflow), 32'd0);

        chk("hold_stable", 32'(hold_viol), 32'd0);
        chk("err_pulse_width", 32'(width_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives device-to-host PS/2 keyboard frames on PS2_CLK/PS2_DAT and decodes scan-code set 2 prefixes.
- Emits one event per key make or break through a valid/ready handshake.
- Sits directly upstream of the escape-room game logic in FPGA_escape_room_top, which consumes the events.
- Receive-only: never drives PS2_CLK/PS2_DAT. The top ties both inout pins to high-Z and feeds them in as inputs.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- TIMEOUT_US, 2000, max gap between PS/2 clock falling edges inside a frame before abort.
- FILTER_LEN, 4, consecutive equal synchronized samples needed to accept a new PS2_CLK level.

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS2_CLK pin, asynchronous
- ps2_dat  in  1  raw PS2_DAT pin, asynchronous
- key_ready  in  1  consumer accepts the event this cycle
- key_valid  out  1  event register holds an undelivered event
- key_code  out  8  scan code, prefixes removed
- key_extended  out  1  event was preceded by E0
- key_released  out  1  event was preceded by F0 (break)
- frame_error  out  1  one-cycle pulse on parity, start, stop or timeout error
- overflow  out  1  sticky; set when an event is dropped; cleared only by reset

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, prefix flags clear, filter state = 1 for both lines.
- Input conditioning:
  - 2-FF synchronizer on both pins.
  - Clock line passes through a FILTER_LEN glitch filter.
  - Sampling event = filtered clock 1->0 transition.
  - Data is sampled from the synchronized data line in the same cycle as the sampling event.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on edge, data 0 -> DATA with bit count 0. Data 1 -> frame_error pulse, stay IDLE.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: stop bit must be 1 and XOR(data, parity) must be 1 (odd parity). Pass -> byte strobe. Fail -> frame_error pulse and prefix flags cleared. Either way -> IDLE.
- Watchdog:
  - Counter of CLK_FREQ_HZ/1_000_000*TIMEOUT_US cycles (100000 at defaults), cleared on every edge, counts only while not IDLE.
  - Expiry -> IDLE, frame_error pulse, prefix flags cleared, partial byte discarded.
- Decoder, acting on each byte strobe:
  - E0 sets ext_flag.
  - F0 sets brk_flag.
  - 00, AA, EE, FA, FE, FF are dropped with no event, flags unchanged.
  - Any other byte forms event {ext_flag, brk_flag, byte}, and both flags clear.
- Latency: event is presented on the outputs the cycle after the byte strobe.
- Output register:
  - Transfer occurs when key_valid & key_ready.
  - key_valid stays high until transfer; key_code, key_extended and key_released stay stable while valid.
  - New event with register empty, or with a transfer in the same cycle: load it, key_valid = 1.
  - New event while valid & !ready: drop the new event, keep the old one, set overflow.
- frame_error and event production are mutually exclusive in a cycle.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Keep last_make {ext, code, valid}.
  - A make event equal to last_make is suppressed; it does not count as overflow.
  - A break matching last_make clears its valid bit and is emitted.
  - Any different make replaces last_make.
  - Reset clears last_make.
- Undefined: every make, including auto-repeat, is emitted.

Decomposition:
- type_definitions package:
  - ps2_rx_state_t enum {IDLE, DATA, PARITY, STOP}.
  - ps2_key_event_t packed struct {logic extended; logic released; logic [7:0] code}.
- constants package: PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BRK = 8'hF0, the six ignored codes, PS2_FRAME_DATA_BITS = 8.
- Sub-module ps2_frame_rx: synchronizer, filter, frame FSM and watchdog. Outputs byte[7:0], byte_strobe and frame_error.
- ps2_keyboard_rx: instantiates ps2_frame_rx, then adds the decoder, output register and optional filter.

Test Plan:
- Frame 1C (parity 0, stop 1), key_ready=1 -> one cycle key_valid with code 1C, ext 0, rel 0; frame_error stays 0.
- Frames E0, F0, 75 -> a single event {ext 1, rel 1, code 75}; no events for the prefixes.
- Frame 1C with parity bit 1 -> frame_error pulse, no event. A following F0, 1C -> event rel 1, ext 0, showing the flag was cleared by the error.
- key_ready=0: frames 1C then 32 -> key_valid holds 1C, overflow=1. Raise key_ready -> 1C transferred, key_valid drops to 0; 32 is never seen.
- Stop PS2_CLK after 4 data bits for 100001 cycles -> frame_error pulse, FSM IDLE. A following full frame 29 decodes correctly.
- With PS2_TYPEMATIC_FILTER_EN: frames 1C, 1C, 1C, F0, 1C -> exactly two events, make 1C then break 1C. Without the macro -> four events.
